// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Serial frame receiver. Samples the line once per clk and deserialises
//   start / data / [parity] / stop frames into a parallel word held in a
//   one-entry valid/ready output buffer. Error conditions are reported as
//   one-cycle pulses.
//
//   Optional feature macro: SERIAL_RX_PARITY_EN
//     defined   -> a parity bit follows the data bits; PARITY_ODD selects
//                  even (0) or odd (1) parity; parity_err is live.
//     undefined -> no parity bit, parity_err is constant 0.
//
// Parameters
//   DATA_BITS  data bits per frame (5..16)
//   STOP_BITS  stop bits per frame (1 or 2)
//   MSB_FIRST  0: first data bit -> out_data[0]; 1: -> out_data[DATA_BITS-1]
//   PARITY_ODD parity sense when parity is compiled in
//
// Ports
//   clk         clock; everything samples on the rising edge
//   reset       synchronous, active-high reset
//   in          serial line, idle 1, start bit 0
//   out_data    received word, valid while out_valid = 1
//   out_valid   output buffer holds a word
//   out_ready   consumer takes the word when out_valid && out_ready
//   frame_err   pulse: a stop bit was sampled as 0
//   parity_err  pulse: parity mismatch on an otherwise complete frame
//   overrun     pulse: good frame dropped because the buffer was full
//   busy        receiver is not in IDLE
module serial_frame_rx #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int               CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
`ifdef SERIAL_RX_PARITY_EN
        PARITY    = 3'd2,
`endif
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   perr_q, perr_d;
    logic                   ovr_q, ovr_d;
    logic                   busy_q, busy_d;
    logic                   par_bad;
    logic                   done;

`ifdef SERIAL_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic par_bad_q, par_bad_d;
    assign par_bad = par_bad_q;
`else
    // Parity sense has no meaning without a parity bit.
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q  <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
        ovr_d      = 1'b0;
        done       = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif

        // Consumer handshake empties the buffer; a load below overrides it.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!in) begin
                    state_d = DATA;
                    cnt_d   = '0;
`ifdef SERIAL_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            DATA: begin
                if (MSB_FIRST != 0) begin
                    shreg_d = {shreg_q[DATA_BITS-2:0], in};
                end else begin
                    shreg_d = {in, shreg_q[DATA_BITS-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    stop_cnt_d = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                // Even parity: XOR over data and parity bit must be 0.
                par_bad_d  = (^shreg_q) ^ in ^ PAR_SENSE;
                stop_cnt_d = 1'b0;
                state_d    = STOP;
            end
`endif
            STOP: begin
                if (!in) begin
                    // A bad first stop bit ends the frame immediately.
                    ferr_d  = 1'b1;
                    state_d = WAIT_IDLE;
                end else if (stop_cnt_q == LAST_STOP) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // A held-low line must return high before a new start bit counts.
                if (in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done) begin
            if (par_bad) begin
                perr_d = 1'b1;
            end else if (!valid_q || out_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
//   Directed bench for serial_frame_rx. Instance A uses the default
//   configuration (8 data bits, 1 stop, LSB first); instance B uses 12 data
//   bits, 2 stop bits, MSB first. With SERIAL_RX_PARITY_EN defined, two more
//   8-bit instances (even and odd parity) are exercised and frames for A and B
//   carry an even parity bit. Line bits are driven on the falling edge so each
//   rising edge samples one bit; outputs are checked on falling edges.
module tb_serial_frame_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_a, rdy_a, vld_a, ferr_a, perr_a, ovr_a, busy_a;
    logic [7:0]  data_a;
    logic        in_b, rdy_b, vld_b, ferr_b, perr_b, ovr_b, busy_b;
    logic [11:0] data_b;

    int vectors     = 0;
    int miscompares = 0;

    serial_frame_rx dut_a (
        .clk(clk), .reset(reset), .in(in_a), .out_data(data_a), .out_valid(vld_a),
        .out_ready(rdy_a), .frame_err(ferr_a), .parity_err(perr_a), .overrun(ovr_a),
        .busy(busy_a)
    );

    serial_frame_rx #(.DATA_BITS(12), .STOP_BITS(2), .MSB_FIRST(1)) dut_b (
        .clk(clk), .reset(reset), .in(in_b), .out_data(data_b), .out_valid(vld_b),
        .out_ready(rdy_b), .frame_err(ferr_b), .parity_err(perr_b), .overrun(ovr_b),
        .busy(busy_b)
    );

`ifdef SERIAL_RX_PARITY_EN
    logic       in_p, rdy_p;
    logic       vld_e, ferr_e, perr_e, ovr_e, busy_e;
    logic       vld_o, ferr_o, perr_o, ovr_o, busy_o;
    logic [7:0] data_e, data_o;

    serial_frame_rx #(.PARITY_ODD(0)) dut_e (
        .clk(clk), .reset(reset), .in(in_p), .out_data(data_e), .out_valid(vld_e),
        .out_ready(rdy_p), .frame_err(ferr_e), .parity_err(perr_e), .overrun(ovr_e),
        .busy(busy_e)
    );

    serial_frame_rx #(.PARITY_ODD(1)) dut_o (
        .clk(clk), .reset(reset), .in(in_p), .out_data(data_o), .out_valid(vld_o),
        .out_ready(rdy_p), .frame_err(ferr_o), .parity_err(perr_o), .overrun(ovr_o),
        .busy(busy_o)
    );

    task automatic bit_p(input logic b);
        @(negedge clk);
        in_p = b;
    endtask

    task automatic frame_p(input logic [7:0] d, input logic pbit);
        bit_p(1'b0);
        for (int i = 0; i < 8; i++) bit_p(d[i]);
        bit_p(pbit);
        bit_p(1'b1);
    endtask
`endif

    // Words delivered by B and error pulses seen on B.
    logic [11:0] got_b[$];
    int          ferr_b_cnt = 0;
    int          perr_b_cnt = 0;
    int          ovr_b_cnt  = 0;

    always @(posedge clk) begin
        if (vld_b && rdy_b) got_b.push_back(data_b);
        if (ferr_b) ferr_b_cnt++;
        if (perr_b) perr_b_cnt++;
        if (ovr_b)  ovr_b_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bit_a(input logic b);
        @(negedge clk);
        in_a = b;
    endtask

    task automatic bit_b(input logic b);
        @(negedge clk);
        in_b = b;
    endtask

    // Returns right after the last stop bit is placed on the line.
    task automatic frame_a(input logic [7:0] d, input logic stopb);
        bit_a(1'b0);
        for (int i = 0; i < 8; i++) bit_a(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        bit_a(^d);
`endif
        bit_a(stopb);
    endtask

    task automatic frame_b(input logic [11:0] d);
        bit_b(1'b0);
        for (int i = 11; i >= 0; i--) bit_b(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        bit_b(^d);
`endif
        bit_b(1'b1);
        bit_b(1'b1);
    endtask

    initial begin
        int          ferr_seen;
        int          vld_seen;
        logic [11:0] w0, w1, w2;

        reset = 1'b1;
        in_a  = 1'b1; rdy_a = 1'b0;
        in_b  = 1'b1; rdy_b = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        in_p  = 1'b1; rdy_p = 1'b0;
`endif
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_valid",  vld_a,  1'b0);
        chk("reset_data",   data_a, 8'h00);
        chk("reset_busy",   busy_a, 1'b0);
        chk("reset_ferr",   ferr_a, 1'b0);
        chk("reset_perr",   perr_a, 1'b0);
        chk("reset_ovr",    ovr_a,  1'b0);
        chk("reset_data_b", data_b, 12'h000);
        reset = 1'b0;
        rdy_b = 1'b1;
        repeat (3) @(negedge clk);

        // B: 12-bit MSB-first, two stop bits, then two back-to-back frames
        frame_b(12'hC3A);
        bit_b(1'b1);
        chk("b_first_valid", vld_b,  1'b1);
        chk("b_first_data",  data_b, 12'hC3A);
        frame_b(12'h001);
        frame_b(12'hFFF);
        bit_b(1'b1);
        bit_b(1'b1);
        w0 = (got_b.size() > 0) ? got_b[0] : 12'hxxx;
        w1 = (got_b.size() > 1) ? got_b[1] : 12'hxxx;
        w2 = (got_b.size() > 2) ? got_b[2] : 12'hxxx;
        chk("b_word_count", got_b.size(), 3);
        chk("b_word0",      w0, 12'hC3A);
        chk("b_word1",      w1, 12'h001);
        chk("b_word2",      w2, 12'hFFF);
        chk("b_no_ferr",    ferr_b_cnt, 0);
        chk("b_no_perr",    perr_b_cnt, 0);
        chk("b_no_ovr",     ovr_b_cnt,  0);
        chk("b_idle_busy",  busy_b, 1'b0);

        // A: 0xA5 LSB-first; valid appears exactly one cycle after the stop sample
        frame_a(8'hA5, 1'b1);
        chk("a5_busy",        busy_a, 1'b1);
        chk("a5_valid_early", vld_a,  1'b0);
        bit_a(1'b1);
        chk("a5_valid",       vld_a,  1'b1);
        chk("a5_data",        data_a, 8'hA5);
        chk("a5_idle_busy",   busy_a, 1'b0);
        chk("a5_no_ferr",     ferr_a, 1'b0);
        rdy_a = 1'b1;
        bit_a(1'b1);
        rdy_a = 1'b0;
        chk("a5_consumed",    vld_a,  1'b0);

        // Bad stop bit followed by a 20-cycle break
        frame_a(8'h55, 1'b0);
        ferr_seen = 0;
        vld_seen  = 0;
        for (int i = 0; i < 20; i++) begin
            bit_a(1'b0);
            if (ferr_a) ferr_seen++;
            if (vld_a)  vld_seen++;
        end
        chk("break_ferr_pulses", ferr_seen, 1);
        chk("break_no_word",     vld_seen,  0);
        chk("break_busy",        busy_a,    1'b1);
        bit_a(1'b1);
        frame_a(8'h3C, 1'b1);
        bit_a(1'b1);
        chk("after_break_valid", vld_a,  1'b1);
        chk("after_break_data",  data_a, 8'h3C);
        chk("after_break_ferr",  ferr_a, 1'b0);
        rdy_a = 1'b1;
        bit_a(1'b1);
        rdy_a = 1'b0;

        // Overrun: buffer full and not read when second frame completes
        frame_a(8'h11, 1'b1);
        frame_a(8'h22, 1'b1);
        bit_a(1'b1);
        chk("ovr_pulse",     ovr_a,  1'b1);
        chk("ovr_keep_data", data_a, 8'h11);
        chk("ovr_keep_vld",  vld_a,  1'b1);
        bit_a(1'b1);
        chk("ovr_one_cycle", ovr_a,  1'b0);
        chk("ovr_data_hold", data_a, 8'h11);
        rdy_a = 1'b1;
        bit_a(1'b1);
        rdy_a = 1'b0;
        chk("ovr_drained",   vld_a,  1'b0);

        // Ready in the completion cycle of the second frame: reload, no overrun
        frame_a(8'h11, 1'b1);
        frame_a(8'h22, 1'b1);
        rdy_a = 1'b1;
        bit_a(1'b1);
        rdy_a = 1'b0;
        chk("swap_data",   data_a, 8'h22);
        chk("swap_valid",  vld_a,  1'b1);
        chk("swap_no_ovr", ovr_a,  1'b0);
        bit_a(1'b1);
        chk("swap_hold",   data_a, 8'h22);

        // Reset in the middle of data bits with a word still buffered
        bit_a(1'b0);
        bit_a(1'b1);
        bit_a(1'b0);
        bit_a(1'b1);
        @(negedge clk);
        chk("mid_busy", busy_a, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", vld_a,  1'b0);
        chk("mid_rst_data",  data_a, 8'h00);
        chk("mid_rst_busy",  busy_a, 1'b0);
        chk("mid_rst_ferr",  ferr_a, 1'b0);
        chk("mid_rst_ovr",   ovr_a,  1'b0);
        reset = 1'b0;
        in_a  = 1'b1;
        bit_a(1'b1);
        frame_a(8'h5A, 1'b1);
        bit_a(1'b1);
        chk("post_rst_valid", vld_a,  1'b1);
        chk("post_rst_data",  data_a, 8'h5A);

`ifdef SERIAL_RX_PARITY_EN
        // 0x07 has odd weight: parity 1 satisfies even, parity 0 satisfies odd
        bit_p(1'b1);
        frame_p(8'h07, 1'b1);
        bit_p(1'b1);
        chk("even_p1_valid", vld_e,  1'b1);
        chk("even_p1_data",  data_e, 8'h07);
        chk("even_p1_perr",  perr_e, 1'b0);
        chk("odd_p1_valid",  vld_o,  1'b0);
        chk("odd_p1_perr",   perr_o, 1'b1);
        rdy_p = 1'b1;
        bit_p(1'b1);
        rdy_p = 1'b0;
        frame_p(8'h07, 1'b0);
        bit_p(1'b1);
        chk("even_p0_valid", vld_e,  1'b0);
        chk("even_p0_perr",  perr_e, 1'b1);
        chk("odd_p0_valid",  vld_o,  1'b1);
        chk("odd_p0_data",   data_o, 8'h07);
        chk("odd_p0_perr",   perr_o, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Parametrised serial frame receiver that samples one line bit per `clk` and deserialises start/data/[parity]/stop frames into parallel words. It has configurable data width, bit order and stop-bit count. A one-entry valid/ready output buffer and sticky-free error pulses let it feed a downstream FIFO or register file without losing frames silently. It replaces fixed 8-bit, single-stop, done-pulse receivers in the serial input path.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5..16.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `MSB_FIRST`, 0: 0 means the first data bit lands in `out_data[0]`; 1 means it lands in `out_data[DATA_BITS-1]`.
- `PARITY_ODD`, 0: parity sense when parity is compiled in. 0 = even, 1 = odd.
- `clk`  input  1  clock; reset is synchronous, active-high, on clock `clk`.
- `reset`  input  1  synchronous, active-high reset.
- `in`  input  1  serial line. Idle level 1, start bit 0; sampled on every rising `clk`.
- `out_data`  output  DATA_BITS  received word; valid while `out_valid`=1.
- `out_valid`  output  1  a word is held in the output buffer.
- `out_ready`  input  1  consumer accepts the word on a cycle where `out_valid && out_ready`.
- `frame_err`  output  1  one-cycle pulse: a stop bit was sampled as 0.
- `parity_err`  output  1  one-cycle pulse: parity mismatch. Tied 0 when parity is compiled out.
- `overrun`  output  1  one-cycle pulse: a good frame completed while the buffer was full and not being read.
- `busy`  output  1  high in every state except IDLE.

## Operation
- States: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE
  - `in`=0 → DATA; this cycle is the start bit.
  - `in`=1 → stay in IDLE.
- DATA
  - Samples one bit per cycle into the shift register, in the order set by `MSB_FIRST`.
  - After `DATA_BITS` samples → PARITY (if compiled in), otherwise → STOP.
  - Bit counter width is `$clog2(DATA_BITS+1)`; cleared on entry to DATA.
- PARITY
  - Samples one bit, then → STOP.
  - Mismatch is recorded. When `PARITY_ODD`=0, mismatch means the XOR of the data bits and the parity bit is 1; the expected XOR is inverted when `PARITY_ODD`=1.
- STOP
  - Samples `STOP_BITS` bits.
  - Any stop sample equal to 0 → `frame_err` pulse on the next cycle, no word is delivered, then → WAIT_IDLE. If the failing sample is the first of two stop bits, the second is not sampled.
  - Last stop sample equal to 1 → frame complete, then → IDLE.
- WAIT_IDLE
  - Stays until `in`=1, then → IDLE. A held-low line (break) therefore never restarts a frame.
- Frame completion (all stop bits 1)
  - Parity error recorded: `parity_err` pulses and the word is discarded.
  - Otherwise, buffer empty or being read (`out_valid && out_ready`) in that cycle: word is loaded, `out_valid`=1 next cycle.
  - Otherwise (buffer full, `out_ready`=0): `overrun` pulses, the new word is dropped, and the old word and `out_valid` are unchanged.
- Buffer behaviour
  - `out_valid` clears on the cycle after `out_valid && out_ready` unless a new word loads in that same cycle.
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- Back-to-back frames: in the first cycle after the final stop sample the FSM is in IDLE, and `in`=0 there is a new start bit. Minimum frame period is 1+`DATA_BITS`+P+`STOP_BITS` cycles (P = 1 with parity, else 0).

## Timing
- Reset values: state IDLE, bit counter 0, shift register 0, `out_data`=0, `out_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0.
- Reset asserted mid-frame aborts the frame with no error pulse and discards the buffered word.
- Start bit sampled at cycle t:
  - Data bits are sampled at t+1 .. t+`DATA_BITS`.
  - Parity (if present) is sampled at t+`DATA_BITS`+1.
  - Last stop bit is sampled at t+L, with L = `DATA_BITS`+P+`STOP_BITS`.
  - `out_valid` rises at t+L+1; error pulses also appear at t+L+1, or one cycle after the failing stop sample.
- All outputs are registered; there is no combinational path from `in` or `out_ready` to any output.

## Configuration
- `SERIAL_RX_PARITY_EN` defined: the PARITY state, parity check and `parity_err` logic are compiled in, and `PARITY_ODD` selects the parity sense.
- Undefined: the PARITY state is absent, frames carry no parity bit, `parity_err` is constant 0, and `PARITY_ODD` is ignored.

## Test plan
- Defaults, no parity: idle 1s, then 0, data 0xA5 LSB-first, then 1; `out_valid` rises 10 cycles after the start bit with `out_data`=0xA5; `out_ready`=1 clears it next cycle.
- `DATA_BITS`=12, `STOP_BITS`=2, `MSB_FIRST`=1: send 0xC3A, then two back-to-back frames (0x001, 0xFFF) with `out_ready`=1; all three words are delivered in order with no errors.
- Stop bit = 0 on an 8-bit frame, line held 0 for 20 cycles, then 1, then a valid 0x3C frame: one `frame_err` pulse, no word during the break, then 0x3C delivered.
- `out_ready`=0, two good frames 0x11 then 0x22: `out_data` stays 0x11 and `overrun` pulses once. Repeat with `out_ready` pulsed exactly in the completion cycle of the second frame: 0x22 loads and there is no overrun.
- With `SERIAL_RX_PARITY_EN`, even parity: 0x07 with parity 1 is delivered; 0x07 with parity 0 gives a `parity_err` pulse and no `out_valid`. With `PARITY_ODD`=1 the results are inverted.
- Assert `reset` in the middle of the data bits: all outputs go to 0; the next frame, 0x5A, is received correctly.
